// File: rtl/decode_unit.sv
// Decode stage: splits a 16-bit instruction into register/address fields,
// stalls on scoreboard hazards and holds one decoded instruction for execute.
module decode_unit #(
  parameter int unsigned DATA_W   = 16,
  parameter logic [3:0]  OP_NOP   = 4'h0,
  parameter logic [3:0]  OP_LOAD  = 4'hC,
  parameter logic [3:0]  OP_STORE = 4'hD,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       instr,
  input  logic              flush,
  output logic [3:0]        srcReg1,
  output logic [3:0]        srcReg2,
  input  logic [DATA_W-1:0] srcRegVal1,
  input  logic [DATA_W-1:0] srcRegVal2,
  input  logic              inuse1,
  input  logic              inuse2,
  output logic [3:0]        nextDestReg,
  output logic              destClaim,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        opcode,
  output logic [3:0]        destReg,
  output logic [DATA_W-1:0] srcVal1,
  output logic [DATA_W-1:0] srcVal2,
  output logic [7:0]        memAddr,
  output logic              used1,
  output logic              used2,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [3:0]        op;
  logic              is_load, is_store, is_alu;
  logic              need1, need2, has_dest;
  logic [3:0]        src1, src2, dest;
  logic [7:0]        addr;
  logic              hazard, accept;

  logic              out_valid_q, out_valid_d;
  logic [3:0]        opcode_q, opcode_d;
  logic [3:0]        dest_reg_q, dest_reg_d;
  logic [DATA_W-1:0] src_val1_q, src_val1_d;
  logic [DATA_W-1:0] src_val2_q, src_val2_d;
  logic [7:0]        mem_addr_q, mem_addr_d;
  logic              used1_q, used1_d;
  logic              used2_q, used2_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  always_comb begin
    op       = instr[15:12];
    is_load  = (op == OP_LOAD);
    is_store = (op == OP_STORE);
    is_alu   = !is_load && !is_store && (op != OP_NOP);
    need1    = is_alu || is_store;
    need2    = is_alu;
    has_dest = is_alu || is_load;
    src1     = '0;
    src2     = '0;
    dest     = '0;
    addr     = '0;
    if (is_alu) begin
      dest = instr[11:8];
      src1 = instr[7:4];
      src2 = instr[3:0];
    end else if (is_load) begin
      dest = instr[3:0];
      addr = instr[11:4];
    end else if (is_store) begin
      src1 = instr[3:0];
      addr = instr[11:4];
    end
  end

  assign hazard   = in_valid && ((need1 && inuse1) || (need2 && inuse2));
  assign in_ready = rst && !flush && !hazard && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  assign srcReg1     = src1;
  assign srcReg2     = src2;
  assign nextDestReg = dest;
  assign destClaim   = accept && has_dest;

  always_comb begin
    out_valid_d = out_valid_q;
    opcode_d    = opcode_q;
    dest_reg_d  = dest_reg_q;
    src_val1_d  = src_val1_q;
    src_val2_d  = src_val2_q;
    mem_addr_d  = mem_addr_q;
    used1_d     = used1_q;
    used2_d     = used2_q;
    stall_cnt_d = stall_cnt_q;
    if (hazard && !flush && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    // flush only retires the valid bit; payload stays as-is
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      opcode_d    = op;
      dest_reg_d  = dest;
      src_val1_d  = need1 ? srcRegVal1 : '0;
      src_val2_d  = need2 ? srcRegVal2 : '0;
      mem_addr_d  = addr;
      used1_d     = need1;
      used2_d     = need2;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      opcode_q    <= '0;
      dest_reg_q  <= '0;
      src_val1_q  <= '0;
      src_val2_q  <= '0;
      mem_addr_q  <= '0;
      used1_q     <= 1'b0;
      used2_q     <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      opcode_q    <= opcode_d;
      dest_reg_q  <= dest_reg_d;
      src_val1_q  <= src_val1_d;
      src_val2_q  <= src_val2_d;
      mem_addr_q  <= mem_addr_d;
      used1_q     <= used1_d;
      used2_q     <= used2_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign opcode    = opcode_q;
  assign destReg   = dest_reg_q;
  assign srcVal1   = src_val1_q;
  assign srcVal2   = src_val2_q;
  assign memAddr   = mem_addr_q;
  assign used1     = used1_q;
  assign used2     = used2_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_decode_unit.sv
// Bench for decode_unit: directed scenarios then random traffic, all checked
// against a cycle-level reference model; a CNT_W=2 copy covers saturation.
module tb_decode_unit;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, inuse1, inuse2, out_ready;
  logic [15:0] instr;
  logic [15:0] rf [16];

  logic        in_ready, destClaim, out_valid, used1, used2;
  logic [3:0]  srcReg1, srcReg2, nextDestReg, opcode, destReg;
  logic [15:0] srcVal1, srcVal2, stall_cnt;
  logic [7:0]  memAddr;

  logic        b_in_ready, b_destClaim, b_out_valid, b_used1, b_used2;
  logic [3:0]  b_srcReg1, b_srcReg2, b_nextDestReg, b_opcode, b_destReg;
  logic [15:0] b_srcVal1, b_srcVal2;
  logic [7:0]  b_memAddr;
  logic [1:0]  b_stall_cnt;

  int unsigned checks = 0;
  int unsigned fails  = 0;

  // reference model state
  bit          m_ov, m_known;
  int unsigned m_op, m_dest, m_v1, m_v2, m_addr, m_u1, m_u2, m_cnt, m_cnt2;

  always #5 clk = ~clk;

  decode_unit #(.DATA_W(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .flush(flush), .srcReg1(srcReg1), .srcReg2(srcReg2),
    .srcRegVal1(rf[srcReg1]), .srcRegVal2(rf[srcReg2]),
    .inuse1(inuse1), .inuse2(inuse2), .nextDestReg(nextDestReg), .destClaim(destClaim),
    .out_valid(out_valid), .out_ready(out_ready), .opcode(opcode), .destReg(destReg),
    .srcVal1(srcVal1), .srcVal2(srcVal2), .memAddr(memAddr), .used1(used1),
    .used2(used2), .stall_cnt(stall_cnt));

  decode_unit #(.DATA_W(16), .CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .instr(instr),
    .flush(flush), .srcReg1(b_srcReg1), .srcReg2(b_srcReg2),
    .srcRegVal1(rf[b_srcReg1]), .srcRegVal2(rf[b_srcReg2]),
    .inuse1(inuse1), .inuse2(inuse2), .nextDestReg(b_nextDestReg), .destClaim(b_destClaim),
    .out_valid(b_out_valid), .out_ready(out_ready), .opcode(b_opcode), .destReg(b_destReg),
    .srcVal1(b_srcVal1), .srcVal2(b_srcVal2), .memAddr(b_memAddr), .used1(b_used1),
    .used2(b_used2), .stall_cnt(b_stall_cnt));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Instruction-format rules expressed directly as a table lookup on the opcode.
  task automatic decode(input logic [15:0] ins, output int unsigned n1, output int unsigned n2,
                        output int unsigned hd, output int unsigned d, output int unsigned s1,
                        output int unsigned s2, output int unsigned a);
    int unsigned o = ins / 4096;
    n1 = 0; n2 = 0; hd = 0; d = 0; s1 = 0; s2 = 0; a = 0;
    case (o)
      0:  ;
      12: begin hd = 1; d = ins % 16; a = (ins / 16) % 256; end
      13: begin n1 = 1; s1 = ins % 16; a = (ins / 16) % 256; end
      default: begin
        n1 = 1; n2 = 1; hd = 1;
        d = (ins / 256) % 16; s1 = (ins / 16) % 16; s2 = ins % 16;
      end
    endcase
  endtask

  task automatic cyc(input logic r, input logic v, input logic [15:0] ins, input logic fl,
                     input logic i1, input logic i2, input logic ordy);
    int unsigned n1, n2, hd, d, s1, s2, a;
    bit hz, rdy, acc;
    @(negedge clk);
    rst = r; in_valid = v; instr = ins; flush = fl;
    inuse1 = i1; inuse2 = i2; out_ready = ordy;
    #1;
    decode(ins, n1, n2, hd, d, s1, s2, a);
    hz  = v && ((n1 == 1 && i1) || (n2 == 1 && i2));
    rdy = r && !fl && !hz && (!m_ov || ordy);
    acc = v && rdy;
    check("in_ready",    32'(in_ready),    32'(rdy));
    check("destClaim",   32'(destClaim),   32'(acc && hd == 1));
    check("nextDestReg", 32'(nextDestReg), d);
    check("srcReg1",     32'(srcReg1),     s1);
    check("srcReg2",     32'(srcReg2),     s2);
    if (!r) begin
      m_ov = 0; m_known = 1; m_op = 0; m_dest = 0; m_v1 = 0; m_v2 = 0;
      m_addr = 0; m_u1 = 0; m_u2 = 0; m_cnt = 0; m_cnt2 = 0;
    end else begin
      if (hz && !fl) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      if (fl) begin
        m_ov = 0; m_known = 0;
      end else if (acc) begin
        m_ov = 1; m_known = 1; m_op = ins / 4096; m_dest = d;
        m_v1 = n1 ? rf[s1] : 0; m_v2 = n2 ? rf[s2] : 0;
        m_addr = a; m_u1 = n1; m_u2 = n2;
      end else if (m_ov && ordy) begin
        m_ov = 0; m_known = 0;
      end
    end
    @(posedge clk);
    #1;
    check("out_valid",   32'(out_valid),   32'(m_ov));
    check("b_out_valid", 32'(b_out_valid), 32'(m_ov));
    check("stall_cnt",   32'(stall_cnt),   m_cnt);
    check("b_stall_cnt", 32'(b_stall_cnt), m_cnt2);
    if (m_known) begin
      check("opcode",  32'(opcode),  m_op);
      check("destReg", 32'(destReg), m_dest);
      check("srcVal1", 32'(srcVal1), m_v1);
      check("srcVal2", 32'(srcVal2), m_v2);
      check("memAddr", 32'(memAddr), m_addr);
      check("used1",   32'(used1),   m_u1);
      check("used2",   32'(used2),   m_u2);
    end
  endtask

  initial begin
    rst = 0; in_valid = 0; instr = '0; flush = 0; inuse1 = 0; inuse2 = 0; out_ready = 1;
    m_ov = 0; m_known = 0;
    for (int i = 0; i < 16; i++) rf[i] = 16'($urandom);

    cyc(0, 0, 16'h0000, 0, 0, 0, 1);
    cyc(0, 1, 16'h1234, 0, 0, 0, 1);
    // ALU, LOAD, STORE back to back
    cyc(1, 1, 16'h1234, 0, 0, 0, 1);
    check("alu_opcode", 32'(opcode), 32'h1);
    check("alu_dest",   32'(destReg), 32'h2);
    check("alu_val1",   32'(srcVal1), 32'(rf[3]));
    check("alu_val2",   32'(srcVal2), 32'(rf[4]));
    cyc(1, 1, 16'hC5A7, 0, 0, 0, 1);
    check("ld_dest", 32'(destReg), 32'h7);
    check("ld_addr", 32'(memAddr), 32'h5A);
    cyc(1, 1, 16'hD5A3, 0, 0, 0, 1);
    check("st_used1", 32'(used1), 32'h1);
    check("st_addr",  32'(memAddr), 32'h5A);
    // dependency stall then release
    cyc(1, 1, 16'h1234, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, 1, 16'h2256, 0, 1, 0, 1);
    check("stall_bubble", 32'(out_valid), 32'h0);
    cyc(1, 1, 16'h2256, 0, 0, 0, 1);
    // backpressure hold
    cyc(1, 1, 16'h1234, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 16'h3321, 0, 0, 0, 0);
    cyc(1, 1, 16'h3321, 0, 0, 0, 1);
    // flush beats in_valid and out_ready
    cyc(1, 1, 16'h4567, 1, 0, 0, 1);
    // counter saturation and reset mid-stall
    cyc(0, 0, 16'h0000, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(1, 1, 16'h5123, 0, 0, 1, 1);
    check("cnt_five",  32'(stall_cnt), 32'd5);
    check("cnt_sat2",  32'(b_stall_cnt), 32'd3);
    cyc(0, 1, 16'h5123, 0, 0, 1, 1);
    check("rst_cnt", 32'(stall_cnt), 32'd0);

    for (int n = 0; n < 3000; n++) begin
      logic [15:0] ins;
      int unsigned sel;
      ins = 16'($urandom);
      sel = $urandom_range(0, 9);
      if (sel == 0) ins[15:12] = 4'h0;
      else if (sel == 1) ins[15:12] = 4'hC;
      else if (sel == 2) ins[15:12] = 4'hD;
      cyc($urandom_range(0, 49) != 0, $urandom_range(0, 9) < 7, ins,
          $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/decode_unit.md
DECODE_UNIT -- requirements
Module: decode_unit

Interface
REQ-001 Parameter DATA_W, default 16, width of register operand values.
REQ-002 Parameter OP_NOP, default 4'h0, opcode with no sources and no destination.
REQ-003 Parameter OP_LOAD, default 4'hC, load opcode.
REQ-004 Parameter OP_STORE, default 4'hD, store opcode.
REQ-005 Parameter CNT_W, default 16, stall counter width.
REQ-006 clk  in  1  single clock; all state updates on posedge clk.
REQ-007 rst  in  1  reset, synchronous and active-low.
REQ-008 in_valid  in  1  fetch presents instr.
REQ-009 in_ready  out  1  decode accepts instr this cycle.
REQ-010 instr  in  16  instruction; opcode [15:12].
REQ-011 flush  in  1  discard the held instruction and block acceptance this cycle.
REQ-012 srcReg1, srcReg2  out  4 each  regfile read indices.
REQ-013 srcRegVal1, srcRegVal2  in  DATA_W each  regfile read data.
REQ-014 inuse1, inuse2  in  1 each  scoreboard busy bit of srcReg1/srcReg2.
REQ-015 nextDestReg  out  4  destination to mark busy.
REQ-016 destClaim  out  1  one-cycle pulse: regfile sets busy on nextDestReg at the same posedge.
REQ-017 out_valid  out  1  decoded instruction valid to execute.
REQ-018 out_ready  in  1  execute accepts this cycle.
REQ-019 opcode, destReg  out  4 each; srcVal1, srcVal2  out  DATA_W each; memAddr  out  8; used1, used2  out  1 each.
REQ-020 stall_cnt  out  CNT_W  hazard-stall cycle counter.

Function
REQ-021 Field decode SHALL be: ALU (any opcode other than NOP/LOAD/STORE) dest=[11:8], src1=[7:4], src2=[3:0], needs both sources; LOAD dest=[3:0], addr=[11:4], no sources; STORE src1=[3:0], addr=[11:4], needs src1 only; NOP nothing.
REQ-022 srcReg1/srcReg2 SHALL be combinational from instr per REQ-021 (0 when the source is not needed).
REQ-023 hazard SHALL = in_valid & ((need1 & inuse1) | (need2 & inuse2)).
REQ-024 in_ready SHALL = rst & !flush & !hazard & (!out_valid | out_ready).
REQ-025 On accept (in_valid & in_ready) the output register SHALL load opcode, destReg (0 if none), srcVal1/2 (regfile values when needed, else 0), memAddr (0 for ALU/NOP), used1/2 = need1/2; out_valid=1 next cycle; latency exactly 1 cycle.
REQ-026 destClaim SHALL = accept & has-destination (ALU or LOAD); nextDestReg = decoded dest, else 0.
REQ-027 If out_valid & out_ready and no accept, out_valid SHALL drop to 0 next cycle (bubble).
REQ-028 If out_valid & !out_ready, all outputs SHALL hold unchanged.
REQ-029 flush SHALL force out_valid=0 next cycle, with priority over out_ready and in_valid; held payload fields need not clear.
REQ-030 stall_cnt SHALL increment by 1 on each cycle with hazard & !flush, saturating at all-ones.
REQ-031 Back-to-back dependency (producer accepted at edge N, consumer presented cycle N+1) SHALL stall, since inuse is set at edge N.

Reset
REQ-032 rst=0 at posedge SHALL set out_valid=0, opcode=0, destReg=0, srcVal1=srcVal2=0, memAddr=0, used1=used2=0, stall_cnt=0.
REQ-033 While rst=0, in_ready=0 and destClaim=0.
REQ-034 Reset mid-stall SHALL drop the held instruction without issuing destClaim.

Verification
REQ-035 After reset, instr=16'h1234 valid, inuse=0, out_ready=1 -> next cycle out_valid=1, opcode=1, destReg=2, used1=used2=1, srcVal=regfile values of r3/r4; destClaim=1, nextDestReg=2 in accept cycle.
REQ-036 instr=16'hC5A7 (LOAD) -> destReg=7, memAddr=8'h5A, used1=used2=0; instr=16'hD5A3 (STORE) -> srcReg1=3, used1=1, used2=0, memAddr=8'h5A, destClaim=0.
REQ-037 16'h1234 then 16'h2256 (src r2 busy) -> in_ready=0 while inuse1=1, stall_cnt increments per stalled cycle, out_valid=0 bubble; accept in cycle inuse clears.
REQ-038 out_ready=0 for 3 cycles with out_valid=1 -> outputs stable, in_ready=0, no destClaim; resumes on out_ready=1.
REQ-039 flush with out_valid=1 and in_valid=1 -> out_valid=0 next cycle, no accept, no destClaim.
REQ-040 rst=0 during a stall with stall_cnt=5 -> next cycle all outputs at REQ-032 values; CNT_W=2 bench: 5 hazard cycles -> stall_cnt=3.
